// File: rtl/pifo_access_arbiter.sv
// pifo_access_arbiter: round-robin push arbiter, paced pop issue and occupancy tracking
// for the BMW PIFO task generator. Rev 1.0. Optional counters: define PIFO_ARB_STATS_EN.
`default_nettype none

module pifo_access_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int TREE_NUM      = 4,
  parameter int PRIORITY_NUM  = 16,
  parameter int PTW           = 16,
  parameter int CAPACITY      = 64,
  parameter int MIN_POP_GAP   = 2,
  parameter int POP_LAT       = 2,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int PRIORITY_BITS = $clog2(PRIORITY_NUM),
  parameter int MTW           = TREE_NUM_BITS,
  parameter int DW            = MTW + PTW,
  parameter int OCW           = $clog2(CAPACITY + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_arst_n,
  input  logic [NUM_REQ-1:0]               i_req_push,
  input  logic [NUM_REQ*TREE_NUM_BITS-1:0] i_req_tree_id,
  input  logic [NUM_REQ*PRIORITY_BITS-1:0] i_req_priority,
  input  logic [NUM_REQ*DW-1:0]            i_req_data,
  output logic [NUM_REQ-1:0]               o_req_ack,
  input  logic                             i_pop_req,
  output logic                             o_pop_ack,
  output logic                             o_push,
  output logic [TREE_NUM_BITS-1:0]         o_push_tree_id,
  output logic [PRIORITY_BITS-1:0]         o_push_priority,
  output logic [DW-1:0]                    o_push_data,
  output logic                             o_pop,
  input  logic                             i_task_fifo_full,
  input  logic [TREE_NUM_BITS-1:0]         i_pop_tree_id,
  input  logic [DW-1:0]                    i_pop_data,
  output logic                             o_pop_valid,
  output logic [TREE_NUM_BITS-1:0]         o_pop_tree_id,
  output logic [DW-1:0]                    o_pop_data,
  output logic [OCW-1:0]                   o_occupancy
`ifdef PIFO_ARB_STATS_EN
  ,
  output logic [15:0]                      o_stat_push_cnt,
  output logic [15:0]                      o_stat_pop_cnt,
  output logic [15:0]                      o_stat_stall_cnt
`endif
);

  localparam int RPW = $clog2(NUM_REQ);
  localparam int GCW = (MIN_POP_GAP > 1) ? $clog2(MIN_POP_GAP) : 1;
  localparam logic [OCW-1:0] CAP_V    = OCW'(CAPACITY);
  localparam logic [GCW-1:0] GAP_INIT = GCW'(MIN_POP_GAP - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } pop_state_t;

  pop_state_t         pop_state;
  logic [GCW-1:0]     gap_cnt;
  logic [RPW-1:0]     rr_ptr;
  logic [RPW-1:0]     grant_idx;
  logic [RPW-1:0]     scan_idx;
  logic               grant_found;
  logic               push_grant;
  logic               pop_ack;
  logic [POP_LAT-1:0] pop_sr;

  // First asserted request at or after rr_ptr; the index wraps for free since NUM_REQ is 2^n.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = rr_ptr + RPW'(i);
      if (!grant_found && i_req_push[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Gated by reset so the combinational handshakes stay low while reset is held.
  assign pop_ack    = i_arst_n && (pop_state == IDLE) && i_pop_req && (o_occupancy != '0);
  assign push_grant = i_arst_n && grant_found && !i_task_fifo_full &&
                      ((o_occupancy < CAP_V) || pop_ack);

  assign o_req_ack = push_grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign o_pop_ack = pop_ack;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rr_ptr          <= '0;
      o_push          <= 1'b0;
      o_push_tree_id  <= '0;
      o_push_priority <= '0;
      o_push_data     <= '0;
    end else begin
      o_push <= push_grant;
      if (push_grant) begin
        rr_ptr          <= grant_idx + RPW'(1);
        o_push_tree_id  <= i_req_tree_id[grant_idx*TREE_NUM_BITS +: TREE_NUM_BITS];
        o_push_priority <= i_req_priority[grant_idx*PRIORITY_BITS +: PRIORITY_BITS];
        o_push_data     <= i_req_data[grant_idx*DW +: DW];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_occupancy <= '0;
    end else begin
      case ({push_grant, pop_ack})
        2'b10:   o_occupancy <= o_occupancy + OCW'(1);
        2'b01:   o_occupancy <= o_occupancy - OCW'(1);
        default: o_occupancy <= o_occupancy;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      pop_state <= IDLE;
      gap_cnt   <= '0;
      o_pop     <= 1'b0;
    end else begin
      o_pop <= pop_ack;
      case (pop_state)
        IDLE: begin
          if (pop_ack) begin
            gap_cnt <= GAP_INIT;
            if (MIN_POP_GAP > 1) pop_state <= GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GCW'(1);
          if (gap_cnt == GCW'(1)) pop_state <= IDLE;
        end
        default: pop_state <= IDLE;
      endcase
    end
  end

  generate
    if (POP_LAT == 1) begin : g_pop_sr_single
      always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) pop_sr <= '0;
        else           pop_sr <= o_pop;
      end
    end else begin : g_pop_sr_multi
      always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) pop_sr <= '0;
        else           pop_sr <= {pop_sr[POP_LAT-2:0], o_pop};
      end
    end
  endgenerate

  // Tail of the latency pipe marks the cycle the tree presents pop data.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_pop_valid   <= 1'b0;
      o_pop_tree_id <= '0;
      o_pop_data    <= '0;
    end else begin
      o_pop_valid <= pop_sr[POP_LAT-1];
      if (pop_sr[POP_LAT-1]) begin
        o_pop_tree_id <= i_pop_tree_id;
        o_pop_data    <= i_pop_data;
      end
    end
  end

`ifdef PIFO_ARB_STATS_EN
  logic stall;
  assign stall = (|i_req_push) && !push_grant;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_stat_push_cnt  <= '0;
      o_stat_pop_cnt   <= '0;
      o_stat_stall_cnt <= '0;
    end else begin
      if (push_grant && (o_stat_push_cnt != 16'hFFFF))  o_stat_push_cnt  <= o_stat_push_cnt + 16'd1;
      if (pop_ack && (o_stat_pop_cnt != 16'hFFFF))      o_stat_pop_cnt   <= o_stat_pop_cnt + 16'd1;
      if (stall && (o_stat_stall_cnt != 16'hFFFF))      o_stat_stall_cnt <= o_stat_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pifo_access_arbiter.sv
// tb_pifo_access_arbiter: scoreboard bench for pifo_access_arbiter (default parameters).
`default_nettype none

module tb_pifo_access_arbiter;

  localparam int NREQ = 4;
  localparam int TB   = 2;
  localparam int PB   = 4;
  localparam int DW   = 18;
  localparam int OCW  = 7;
  localparam int PLAT = 2;

  logic              clk;
  logic              arst_n;
  logic [NREQ-1:0]   req_push;
  logic [NREQ*TB-1:0] req_tree_id;
  logic [NREQ*PB-1:0] req_priority;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic              pop_req;
  logic              pop_ack;
  logic              push;
  logic [TB-1:0]     push_tree_id;
  logic [PB-1:0]     push_priority;
  logic [DW-1:0]     push_data;
  logic              pop;
  logic              fifo_full;
  logic [TB-1:0]     pop_tree_id_in;
  logic [DW-1:0]     pop_data_in;
  logic              pop_valid;
  logic [TB-1:0]     pop_tree_id;
  logic [DW-1:0]     pop_data;
  logic [OCW-1:0]    occupancy;

  pifo_access_arbiter #(
    .NUM_REQ(4), .TREE_NUM(4), .PRIORITY_NUM(16), .PTW(16),
    .CAPACITY(64), .MIN_POP_GAP(2), .POP_LAT(PLAT)
  ) dut (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_req_push(req_push), .i_req_tree_id(req_tree_id),
    .i_req_priority(req_priority), .i_req_data(req_data),
    .o_req_ack(req_ack), .i_pop_req(pop_req), .o_pop_ack(pop_ack),
    .o_push(push), .o_push_tree_id(push_tree_id),
    .o_push_priority(push_priority), .o_push_data(push_data),
    .o_pop(pop), .i_task_fifo_full(fifo_full),
    .i_pop_tree_id(pop_tree_id_in), .i_pop_data(pop_data_in),
    .o_pop_valid(pop_valid), .o_pop_tree_id(pop_tree_id),
    .o_pop_data(pop_data), .o_occupancy(occupancy)
  );

  typedef struct {
    int            due;
    logic [TB-1:0] tid;
    logic [PB-1:0] pri;
    logic [DW-1:0] data;
  } push_exp_t;

  typedef struct {
    int            due;
    logic [TB-1:0] tid;
    logic [DW-1:0] data;
  } pop_exp_t;

  push_exp_t push_q[$];
  pop_exp_t  pop_q[$];
  int        issue_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int occ_model = 0;
  int exp_rr    = 0;

  logic [TB-1:0] fld_tid  [NREQ];
  logic [PB-1:0] fld_pri  [NREQ];
  logic [DW-1:0] fld_data [NREQ];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tree model: pop result is a known function of the cycle it is presented in.
  function automatic logic [DW-1:0] pop_data_at(input int c);
    return {2'(c), 16'(c * 3 + 'h5A00)};
  endfunction

  function automatic logic [TB-1:0] tid_at(input int c);
    return 2'(c + 1);
  endfunction

  assign pop_tree_id_in = tid_at(cyc);
  assign pop_data_in    = pop_data_at(cyc);

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (req[idx]) return NREQ'(1) << idx;
    end
    return '0;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic load_fields(input int seed);
    for (int i = 0; i < NREQ; i++) begin
      fld_tid[i]  = 2'(i + seed);
      fld_pri[i]  = 4'(i * 5 + seed);
      fld_data[i] = {2'(i + seed), 16'(seed * 256 + i * 17 + 3)};
      req_tree_id[i*TB +: TB]  = fld_tid[i];
      req_priority[i*PB +: PB] = fld_pri[i];
      req_data[i*DW +: DW]     = fld_data[i];
    end
  endtask

  // Drive one cycle's inputs, check the handshakes, queue what must follow.
  task automatic run_cycle(input logic [NREQ-1:0] req, input logic full, input logic preq,
                           input logic [NREQ-1:0] exp_ack, input logic exp_pack);
    req_push  = req;
    fifo_full = full;
    pop_req   = preq;
    @(negedge clk);
    check_eq("occupancy", 64'(occupancy), 64'(occ_model));
    check_eq("req_ack", 64'(req_ack), 64'(exp_ack));
    check_eq("pop_ack", 64'(pop_ack), 64'(exp_pack));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ack[i]) begin
        push_exp_t e;
        e.due  = cyc + 1;
        e.tid  = fld_tid[i];
        e.pri  = fld_pri[i];
        e.data = fld_data[i];
        push_q.push_back(e);
        exp_rr = (i + 1) % NREQ;
      end
    end
    if (exp_pack) begin
      pop_exp_t p;
      p.due  = cyc + 2 + PLAT;
      p.tid  = tid_at(cyc + 1 + PLAT);
      p.data = pop_data_at(cyc + 1 + PLAT);
      pop_q.push_back(p);
      issue_q.push_back(cyc + 1);
    end
    if (exp_ack != '0) occ_model++;
    if (exp_pack) occ_model--;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_ack", 64'(req_ack), 64'd0);
    check_eq("rst_pop_ack", 64'(pop_ack), 64'd0);
    check_eq("rst_push", 64'(push), 64'd0);
    check_eq("rst_push_data", 64'({push_tree_id, push_priority, push_data}), 64'd0);
    check_eq("rst_pop", 64'(pop), 64'd0);
    check_eq("rst_pop_valid", 64'(pop_valid), 64'd0);
    check_eq("rst_pop_data", 64'({pop_tree_id, pop_data}), 64'd0);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
  endtask

  always @(negedge clk) begin
    if (push_q.size() != 0 && push_q[0].due == cyc) begin
      push_exp_t e;
      e = push_q.pop_front();
      check_eq("push_valid", 64'(push), 64'd1);
      check_eq("push_tree_id", 64'(push_tree_id), 64'(e.tid));
      check_eq("push_priority", 64'(push_priority), 64'(e.pri));
      check_eq("push_data", 64'(push_data), 64'(e.data));
    end else begin
      check_eq("push_idle", 64'(push), 64'd0);
    end
    if (issue_q.size() != 0 && issue_q[0] == cyc) begin
      void'(issue_q.pop_front());
      check_eq("pop_issue", 64'(pop), 64'd1);
    end else begin
      check_eq("pop_quiet", 64'(pop), 64'd0);
    end
    if (pop_q.size() != 0 && pop_q[0].due == cyc) begin
      pop_exp_t p;
      p = pop_q.pop_front();
      check_eq("pop_valid", 64'(pop_valid), 64'd1);
      check_eq("pop_tree_id", 64'(pop_tree_id), 64'(p.tid));
      check_eq("pop_data", 64'(pop_data), 64'(p.data));
    end else begin
      check_eq("pop_valid_idle", 64'(pop_valid), 64'd0);
    end
  end

  initial begin
    arst_n    = 1'b1;
    req_push  = '1;
    pop_req   = 1'b1;
    fifo_full = 1'b0;
    load_fields(0);
    #2 arst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    arst_n   = 1'b1;
    req_push = '0;
    pop_req  = 1'b0;

    // All requesters contending: strict rotation, occupancy climbs to 5.
    load_fields(1);
    run_cycle(4'hF, 1'b0, 1'b0, 4'b0001, 1'b0);
    run_cycle(4'hF, 1'b0, 1'b0, 4'b0010, 1'b0);
    run_cycle(4'hF, 1'b0, 1'b0, 4'b0100, 1'b0);
    run_cycle(4'hF, 1'b0, 1'b0, 4'b1000, 1'b0);
    run_cycle(4'hF, 1'b0, 1'b0, 4'b0001, 1'b0);
    run_cycle(4'h0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Generator FIFO full stalls requester 2; pointer then sits at 3.
    load_fields(2);
    for (int k = 0; k < 3; k++) run_cycle(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0);
    run_cycle(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0);
    run_cycle(4'hF, 1'b0, 1'b0, 4'b1000, 1'b0);

    // Drain 7 elements with pop held: one ack every second cycle.
    for (int k = 0; k < 14; k++) run_cycle(4'h0, 1'b0, 1'b1, 4'h0, (k % 2) == 0);
    run_cycle(4'h0, 1'b0, 1'b1, 4'h0, 1'b0);
    run_cycle(4'b0001, 1'b0, 1'b1, 4'b0001, 1'b0);
    run_cycle(4'h0, 1'b0, 1'b1, 4'h0, 1'b1);
    for (int k = 0; k < 5; k++) run_cycle(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

    // Fill to capacity, then show capacity blocks and a same-cycle pop unblocks.
    load_fields(3);
    for (int k = 0; k < 64; k++) run_cycle(4'hF, 1'b0, 1'b0, rr_pick(4'hF, exp_rr), 1'b0);
    run_cycle(4'hF, 1'b0, 1'b0, 4'h0, 1'b0);
    run_cycle(4'hF, 1'b0, 1'b1, rr_pick(4'hF, exp_rr), 1'b1);
    run_cycle(4'h0, 1'b0, 1'b1, 4'h0, 1'b0);

    // Reset one cycle after o_pop: in-flight pop must vanish.
    arst_n   = 1'b0;
    req_push = '1;
    pop_req  = 1'b0;
    #1;
    check_reset_outputs();
    push_q.delete();
    pop_q.delete();
    issue_q.delete();
    occ_model = 0;
    exp_rr    = 0;
    @(posedge clk);
    #1;
    arst_n   = 1'b1;
    req_push = '0;
    for (int k = 0; k < 5; k++) run_cycle(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    load_fields(4);
    run_cycle(4'hF, 1'b0, 1'b0, 4'b0001, 1'b0);
    run_cycle(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    run_cycle(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);

    check_eq("push_q_drained", 64'(push_q.size()), 64'd0);
    check_eq("pop_q_drained", 64'(pop_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
